// File: rtl/midi_tx.sv
// rtl/midi_tx.sv - MIDI serial transmitter with holding register; optional irq via MIDI_TX_IRQ_EN
module midi_tx #(
    parameter int CLK_DIV = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] d,
    output logic       txd,
    output logic       tdre,
    output logic       busy,
    output logic       ovr,
    output logic       irq
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shifter;
    logic [7:0]    hold;
    logic          hold_full;
    logic          bit_end;
    logic          load_shifter;

    assign bit_end = (baud_cnt == BAUD_LAST);
    // The holding register drains either from idle or exactly at the end of a stop bit,
    // so back-to-back frames have no idle gap between them.
    assign load_shifter = hold_full && ((state == IDLE) || ((state == STOP) && bit_end));

    assign tdre = ~hold_full;
    assign busy = (state != IDLE);

    // Holding register: accepts a write only while empty; a write while full is dropped and flagged
    always_ff @(posedge clock) begin
        if (reset) begin
            hold      <= 8'h00;
            hold_full <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            if (load_shifter) begin
                hold_full <= 1'b0;
            end
            if (enable) begin
                if (hold_full) begin
                    ovr <= 1'b1;
                end else begin
                    hold      <= d;
                    hold_full <= 1'b1;
                end
            end
        end
    end

    // Frame sequencer: baud counter, bit counter, shifter and registered line output
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            shifter  <= 8'h00;
            txd      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (load_shifter) begin
                        state   <= START;
                        shifter <= hold;
                        txd     <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                        txd      <= shifter[0];
                        shifter  <= {1'b0, shifter[7:1]};
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            txd     <= shifter[0];
                            shifter <= {1'b0, shifter[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (load_shifter) begin
                            state   <= START;
                            shifter <= hold;
                            txd     <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    txd      <= 1'b1;
                end
            endcase
        end
    end

`ifdef MIDI_TX_IRQ_EN
    logic irq_q;
    // Interrupt follows tdre one cycle late
    always_ff @(posedge clock) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= tdre;
        end
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule
